// File: rtl/y_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y_alu_pkg
// Description : Op-code constants and default datapath width for y_alu.
// Revision    : 1.0
// ============================================================================
package y_alu_pkg;

    localparam int c_width_default = 32;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;

endpackage
`default_nettype wire

// File: rtl/y_arith.sv
`default_nettype none
// ============================================================================
// Module      : y_arith
// Description : WIDTH-bit adder/subtractor; sub=1 computes a + ~b + 1.
// Revision    : 1.0
// ============================================================================
module y_arith
    import y_alu_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_full;

    assign w_b    = sub ? ~b : b;
    assign w_full = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
    assign sum    = w_full[WIDTH-1:0];
    assign cout   = w_full[WIDTH];

endmodule
`default_nettype wire

// File: rtl/y_alu.sv
`default_nettype none
// ============================================================================
// Module      : y_alu
// Description : Combinational ALU (AND/OR/ADD/SUB/SLT) with zero flag and a
//               registered copy of result and flag.
// Revision    : 1.0
// ============================================================================
module y_alu
    import y_alu_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             ex,
    output logic [WIDTH-1:0] z_q,
    output logic             ex_q
);

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_sub;
    logic [WIDTH-1:0] w_z;
    logic [WIDTH-1:0] r_z_q;
    logic             r_ex_q;

    // SUB and SLT both have op[2] set; the unused 100/101 codes ignore the adder.
    assign w_sub = op[2];

    y_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a    (a),
        .b    (b),
        .sub  (w_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_z = '0;
        case (op)
            c_op_and: w_z = a & b;
            c_op_or:  w_z = a | b;
            c_op_add: w_z = w_sum;
            c_op_sub: w_z = w_sum;
            // Unsigned a < b exactly when the subtraction borrows.
            c_op_slt: w_z = {{(WIDTH-1){1'b0}}, ~w_cout};
            default:  w_z = '0;
        endcase
    end

    assign z  = w_z;
    assign ex = (w_z == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z_q  <= '0;
            r_ex_q <= 1'b1;
        end else begin
            r_z_q  <= w_z;
            r_ex_q <= ex;
        end
    end

    assign z_q  = r_z_q;
    assign ex_q = r_ex_q;

endmodule
`default_nettype wire

// File: tb/tb_y_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_y_alu
// Description : Self-checking bench for y_alu: vector table, register-path
//               sequences and randomized sweep against a reference model.
// Revision    : 1.0
// ============================================================================
module tb_y_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp_z;
        logic         exp_ex;
    } vec_t;

    typedef struct {
        logic [W-1:0] z;
        logic         ex;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] z;
    logic         ex;
    logic [W-1:0] z_q;
    logic         ex_q;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[18];

    y_alu #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .z     (z),
        .ex    (ex),
        .z_q   (z_q),
        .ex_q  (ex_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_z(input logic [W-1:0] ra,
                                           input logic [W-1:0] rb,
                                           input logic [2:0] rop);
        case (rop)
            3'b000:  return ra & rb;
            3'b001:  return ra | rb;
            3'b010:  return ra + rb;
            3'b110:  return ra - rb;
            3'b111:  return (ra < rb) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive at negedge, check combinational outputs, then check the
    // registered copy one edge later via the scoreboard.
    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [2:0] top, input logic [W-1:0] ez,
                        input logic eex, input string name);
        exp_t e;
        exp_t got;
        @(negedge clk);
        a  = ta;
        b  = tb_;
        op = top;
        #1;
        chk({name, ".z"}, z, ez);
        chk({name, ".ex"}, {31'b0, ex}, {31'b0, eex});
        if (reset) begin
            e.z  = '0;
            e.ex = 1'b1;
        end else begin
            e.z  = ez;
            e.ex = eex;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({name, ".z_q"}, z_q, got.z);
        chk({name, ".ex_q"}, {31'b0, ex_q}, {31'b0, got.ex});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;
        logic [W-1:0] rz;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        a       = '0;
        b       = '0;
        op      = 3'b000;

        vecs[0]  = '{32'h0000000F, 32'h000000F0, 3'b000, 32'h00000000, 1'b1};
        vecs[1]  = '{32'h0000000F, 32'h000000F0, 3'b001, 32'h000000FF, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000003, 3'b010, 32'h00000008, 1'b0};
        vecs[4]  = '{32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0};
        vecs[5]  = '{32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h00000001, 32'h80000000, 3'b111, 32'h00000001, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 3'b111, 32'h00000000, 1'b1};
        vecs[8]  = '{32'h12345678, 32'h12345678, 3'b111, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, 32'h00000000, 1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000000, 1'b1};
        vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'h00000000, 1'b1};
        vecs[12] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000, 32'hA5A5A5A5, 1'b0};
        vecs[13] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 3'b001, 32'hA5A5A5A5, 1'b0};
        vecs[14] = '{32'h00000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0};
        vecs[15] = '{32'h00000000, 32'h00000000, 3'b010, 32'h00000000, 1'b1};
        vecs[16] = '{32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1};
        vecs[17] = '{32'h00000010, 32'h00000001, 3'b110, 32'h0000000F, 1'b0};

        // Reset state, with combinational path live during reset.
        step(32'd5, 32'd3, 3'b010, 32'd8, 1'b0, "reset");

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++)
            step(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_z, vecs[i].exp_ex,
                 $sformatf("vec%0d", i));

        // Mid-cycle operand change: z follows at once, z_q waits for the edge.
        @(negedge clk);
        a  = 32'd2;
        b  = 32'd3;
        op = 3'b010;
        @(posedge clk);
        #1;
        chk("reg_add.z_q", z_q, 32'd5);
        chk("reg_add.ex_q", {31'b0, ex_q}, 32'd0);
        #2;
        a = 32'd10;
        #1;
        chk("midcyc.z", z, 32'd13);
        chk("midcyc.z_q_hold", z_q, 32'd5);
        @(posedge clk);
        #1;
        chk("midcyc.z_q", z_q, 32'd13);

        // Reset reasserted: register clears, combinational result unaffected.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2.z_q", z_q, 32'd0);
        chk("rst2.ex_q", {31'b0, ex_q}, 32'd1);
        chk("rst2.z", z, 32'd13);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("resume.z_q", z_q, 32'd13);
        chk("resume.ex_q", {31'b0, ex_q}, 32'd0);

        // Randomized sweep over all ops, half the trials with b == a.
        for (int i = 0; i < 1200; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? ra : $urandom;
            rop = 3'(i % 8);
            rz  = ref_z(ra, rb, rop);
            step(ra, rb, rop, rz, (rz == '0), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y_alu.md
Y_ALU -- requirements
Module: y_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port z, output, WIDTH bits: combinational ALU result.
REQ-006 Port ex, output, 1 bit: combinational zero flag, 1 when z is all zeros.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B.
REQ-009 Port op, input, 3 bits: operation select.
REQ-010 Port z_q, output, WIDTH bits: registered copy of z.
REQ-011 Port ex_q, output, 1 bit: registered copy of ex.

Function
REQ-012 When op = 000, z SHALL be a AND b, bitwise.
REQ-013 When op = 001, z SHALL be a OR b, bitwise.
REQ-014 When op = 010, z SHALL be a + b modulo 2^WIDTH; carry-out is discarded and no overflow flag is produced.
REQ-015 When op = 110, z SHALL be a - b modulo 2^WIDTH, computed as a + ~b + 1 on the shared adder.
REQ-016 When op = 111, z SHALL be 1 if a < b as an unsigned compare, else 0, with upper bits zero.
REQ-017 The op = 111 result SHALL be derived from the borrow (carry-out inverted) of the shared subtractor.
REQ-018 For op values 011, 100 and 101, z SHALL be all zeros and ex SHALL be 1.
REQ-019 ex SHALL equal 1 exactly when z = 0, for every op.
REQ-020 z and ex SHALL be purely combinational from a, b and op, with zero-cycle latency, settled within the same timestep, and independent of clk and reset.
REQ-021 On every rising clk edge with reset = 0, z_q SHALL load z and ex_q SHALL load ex, giving one-cycle latency.
REQ-022 Boundary behaviour of the combinational outputs for a = b:
- op 110 SHALL give z = 0 and ex = 1.
- op 111 SHALL give z = 0.
- op 000 and op 001 SHALL give z = a.
REQ-023 Wrap-around: a = FFFFFFFF with b = 1 under op 010 SHALL give z = 0 and ex = 1.
REQ-024 Operand changes mid-cycle SHALL affect z and ex immediately, and z_q and ex_q only at the next edge.

Reset
REQ-025 While reset = 1 at a rising clk edge, z_q SHALL become 0 and ex_q SHALL become 1, matching the zero flag of a zero result.
REQ-026 Reset SHALL have no effect on the combinational z and ex.
REQ-027 Reset deasserted mid-operation SHALL resume normal loading at the first edge with reset = 0.

Structure
REQ-028 Op-code constants AND=000, OR=001, ADD=010, SUB=110 and SLT=111 SHALL live in a shared package y_alu_pkg, together with the default WIDTH.
REQ-029 One sub-module, y_arith, SHALL implement the WIDTH-bit adder/subtractor with inputs a, b and sub, and outputs sum and cout; ADD, SUB and SLT SHALL share it.
REQ-030 The result multiplexer and the zero detect SHALL reside in y_alu.

Verification
REQ-031 a=0000000F, b=000000F0, op=000 -> z=00000000, ex=1; with op=001 -> z=000000FF, ex=0.
REQ-032 a=FFFFFFFF, b=00000001, op=010 -> z=00000000, ex=1; a=00000005, b=00000003, op=010 -> z=00000008.
REQ-033 a=00000003, b=00000005, op=110 -> z=FFFFFFFE, ex=0; a=b=12345678, op=110 -> z=0, ex=1.
REQ-034 a=00000001, b=80000000, op=111 -> z=1 (unsigned compare); a=80000000, b=1 -> z=0, ex=1; a=b -> z=0.
REQ-035 op=100, a=b=FFFFFFFF -> z=0, ex=1.
REQ-036 Register path: reset=1 for one edge -> z_q=0, ex_q=1. Then reset=0 with a=2, b=3, op=010 -> z_q=5, ex_q=0 after one edge. Reset reasserted -> z_q=0 at the next edge.
REQ-037 A randomized bench SHALL run at least 1000 random a/b pairs, with b=a forced on 50% of trials, against a reference model.
- It SHALL sweep all 8 op values.
- It SHALL check z and ex combinationally and z_q and ex_q one cycle later.
